// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared rv32 pipeline register types, NOP bundles and payload widths
package rv_pipe_pkg;

    // Payload widths per stage boundary
    localparam int IF_ID_DATA_W  = 64;  // pc, instruction word
    localparam int ID_EX_DATA_W  = 96;  // pc, operand a, operand b (immediate already muxed in)
    localparam int EX_MEM_DATA_W = 69;  // alu result, store data, rd index
    localparam int MEM_WB_DATA_W = 69;  // writeback data, pc+4, rd index

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       wb_sel;
        logic       reg_write;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic wb_sel;
        logic reg_write;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic wb_sel;
        logic reg_write;
    } mem_wb_ctrl_t;

    // All-zero bundles: no register or memory write can occur from a bubble
    localparam id_ex_ctrl_t  ID_EX_CTRL_NOP  = '0;
    localparam ex_mem_ctrl_t EX_MEM_CTRL_NOP = '0;
    localparam mem_wb_ctrl_t MEM_WB_CTRL_NOP = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    function automatic logic [1:0] state_occupancy(input pipe_state_t s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready inter-stage pipeline register with flush and optional skid entry
module pipe_stage_reg
    import rv_pipe_pkg::*;
#(
    parameter int                DATA_W   = 96,
    parameter int                CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter int                SKID_EN  = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    pipe_state_t       r_state;
    pipe_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_out_valid;
    logic w_in_ready;
    logic w_accept;
    logic w_emit;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // With the skid entry, in_ready decodes only flops so out_ready never reaches it
    always_comb begin
        w_out_valid = (r_state != ST_EMPTY);
        if (SKID_EN != 0) begin
            w_in_ready = (r_state != ST_FULL);
        end else begin
            w_in_ready = !w_out_valid || out_ready;
        end
        w_accept = in_valid && w_in_ready;
        w_emit   = w_out_valid && out_ready;
    end

    // A flushed cycle loads nothing, so the data registers keep their last value
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept && (SKID_EN != 0)) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_emit) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_emit) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_main_data <= '0;
            r_main_ctrl <= CTRL_NOP;
            r_skid_data <= '0;
            r_skid_ctrl <= CTRL_NOP;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end

    always_comb begin
        in_ready  = w_in_ready;
        out_valid = w_out_valid;
        out_data  = r_main_data;
        out_ctrl  = w_out_valid ? r_main_ctrl : CTRL_NOP;
        occupancy = state_occupancy(r_state);
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register used between any two stages of the rv32 pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data payload and a control bundle from one stage to the next.
- Adds valid/ready flow control, synchronous flush (bubble insertion) and an optional skid entry so that back-pressure never forms a combinational ready path.
- On a bubble or flush, the control bundle is forced to a programmable NOP value, so regWrite/memWrite-type bits can never leak.

Parameters:
DATA_W, 96, payload width in bits (immediate, operand data, register indices, PC, ...)
CTRL_W, 8, control bundle width in bits (ALU op/src, mem read/write, wb select, regWrite)
CTRL_NOP, 0, value of the control bundle presented whenever the output is not valid
SKID_EN, 1, 1 = two-entry (main + skid) with registered in_ready; 0 = single entry with combinational in_ready

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
in_valid  input  1  upstream stage presents an instruction
in_ready  output  1  this register can accept this cycle
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control bundle
flush  input  1  synchronous kill of all held entries (branch mispredict / trap)
out_valid  output  1  downstream payload valid
out_ready  input  1  downstream stage accepts this cycle
out_data  output  DATA_W  payload to next stage
out_ctrl  output  CTRL_W  control to next stage; CTRL_NOP when out_valid=0
occupancy  output  2  number of held entries (0..2; max 1 when SKID_EN=0)

Behaviour:
- Reset (resetn low, asynchronous):
  - out_valid=0, out_data=0, out_ctrl=CTRL_NOP, occupancy=0, skid entry invalid.
  - in_ready=1 while in reset when SKID_EN=1; follows the SKID_EN=0 equation otherwise.
  - Reset asserted mid-transfer discards all entries; there is no partial state.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - Payload and control are captured together on accept.
  - Latency: 1 cycle from accept to out_valid when the main entry is empty or emitting.
- Hold rule: while out_valid=1 and out_ready=0, out_data and out_ctrl stay bit-stable.
- Bubble rule: out_ctrl=CTRL_NOP whenever out_valid=0. out_data is don't-care then, but holds its last value (no toggling).
- SKID_EN=1:
  - in_ready = !skid_valid, a register output.
  - States: EMPTY (occ 0), ONE (main valid), FULL (main + skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept & emit -> ONE, main <= in. Accept & !emit -> FULL, skid <= in. Emit & !accept -> EMPTY.
  - FULL: in_ready=0. Emit -> ONE, main <= skid.
  - Ordering is strictly FIFO; the skid entry never overtakes main.
- SKID_EN=0:
  - Single entry; in_ready = !out_valid | out_ready (combinational).
  - Accept with simultaneous emit replaces main in the same edge.
- flush:
  - Takes effect at the next clock edge.
  - All entries are invalidated: occupancy=0, out_valid=0, out_ctrl=CTRL_NOP.
  - An accept in the flush cycle is dropped. Upstream sees the handshake complete; the flushed instruction is squashed by design.
  - An emit in the flush cycle still completes downstream.
  - When SKID_EN=1, in_ready=1 in the cycle after flush.
- Simultaneous flush and reset: reset wins.
- in_valid=0 never changes held entries except via emit/flush.
- Widths are passed through unmodified; no sign-extension or truncation.

Decomposition:
- Package rv_pipe_pkg holds:
  - the per-stage control bundle typedefs (id_ex_ctrl_t, ex_mem_ctrl_t, mem_wb_ctrl_t) as packed structs;
  - their NOP constants, used for CTRL_NOP at instantiation;
  - a localparam for each stage payload width.
- The block is flat. The optional skid entry is simple enough to remain inline; no sub-module is needed.

Test Plan:
1. Reset then streaming: SKID_EN=1, out_ready=1, inject in_data=0x11,0x22,0x33 with in_ctrl=0xA5 on consecutive cycles -> each appears on out_data 1 cycle later, in_ready stays 1, occupancy stays 1.
2. Back-pressure fill: out_ready=0, push 0x11 then 0x22 -> occupancy reaches 2, in_ready=0 in the following cycle, out_data holds 0x11 stable. Then raise out_ready -> 0x11, then 0x22 emitted in order, in_ready returns 1.
3. Flush while FULL: occupancy=2, assert flush with in_valid=1, in_data=0x44 -> next cycle out_valid=0, out_ctrl=CTRL_NOP, occupancy=0, and 0x44 never appears on the output.
4. Bubble control: CTRL_NOP=0x00, in_ctrl=0xFF, drop in_valid for one cycle -> out_ctrl=0x00 during that cycle while out_data holds its previous value.
5. SKID_EN=0 pass-through: out_ready toggled 1,0,1 -> in_ready tracks !out_valid|out_ready combinationally, and the accept-and-emit edge replaces main with no lost or duplicated words.
6. Async reset mid-stall: occupancy=2, pulse resetn low between edges -> out_valid=0, out_ctrl=CTRL_NOP, occupancy=0 immediately, without waiting for a clock edge.
